// File: rtl/tick_scheduler.sv
// Programmable two-channel tick generator: produces single-cycle clock enables
// (tick_cont, tick_ru) under a start/stop/clear sequencer with a valid/ready divisor port.
module tick_scheduler #(
  parameter int CNT_W        = 25,
  parameter int DIV_CONT_DEF = 65536,
  parameter int DIV_RU_DEF   = 16777216
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick_cont,
  output logic             tick_ru,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_CONT = CNT_W'(DIV_CONT_DEF);
  localparam logic [CNT_W-1:0] DEF_RU   = CNT_W'(DIV_RU_DEF);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r [2];
  logic [CNT_W-1:0] div_r [2];
  logic [1:0]       tick_r;
  logic [1:0]       wrap_s;
  logic             running_r;
  logic             err_r;
  logic             pend_r;
  logic             pend_sel_r;
  logic [CNT_W-1:0] pend_div_r;
  logic             xfer_s;
  logic             bad_s;
  logic             accept_s;
  logic             direct_s;

  // Sequencer next state: clear beats stop, stop beats start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear || stop) state_nxt_s = IDLE;
        else if (start)    state_nxt_s = RUN;
        else               state_nxt_s = IDLE;
      end
      RUN: begin
        if (clear)     state_nxt_s = IDLE;
        else if (stop) state_nxt_s = PAUSE;
        else           state_nxt_s = RUN;
      end
      PAUSE: begin
        if (clear)      state_nxt_s = IDLE;
        else if (stop)  state_nxt_s = PAUSE;
        else if (start) state_nxt_s = RUN;
        else            state_nxt_s = PAUSE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Wrap detection and config handshake decode; a write outside RUN (or with clear) bypasses the slot.
  always_comb begin
    wrap_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (state_r == RUN && cnt_r[i] == div_r[i] - ONE) wrap_s[i] = 1'b1;
      else                                              wrap_s[i] = 1'b0;
    end
    xfer_s   = cfg_valid & ~pend_r;
    bad_s    = (cfg_div < TWO);
    accept_s = xfer_s & ~bad_s;
    direct_s = accept_s & ((state_r != RUN) | clear);
  end

  // Main state: sequencer, per-channel counters/divisors/ticks and the pending slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      running_r  <= 1'b0;
      err_r      <= 1'b0;
      tick_r     <= 2'b00;
      cnt_r[0]   <= '0;
      cnt_r[1]   <= '0;
      div_r[0]   <= DEF_CONT;
      div_r[1]   <= DEF_RU;
      pend_r     <= 1'b0;
      pend_sel_r <= 1'b0;
      pend_div_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      running_r <= (state_nxt_s == RUN);
      err_r     <= xfer_s & bad_s;
      for (int i = 0; i < 2; i++) begin
        tick_r[i] <= wrap_s[i] & ~clear;
        if (clear || state_r == IDLE)
          cnt_r[i] <= '0;
        else if (wrap_s[i])
          cnt_r[i] <= '0;
        else if (state_r == RUN)
          cnt_r[i] <= cnt_r[i] + ONE;
        else if (direct_s && cfg_sel == 1'(i) && cnt_r[i] >= cfg_div - ONE)
          cnt_r[i] <= '0;
        else
          cnt_r[i] <= cnt_r[i];

        if (direct_s && cfg_sel == 1'(i))
          div_r[i] <= cfg_div;
        else if (pend_r && pend_sel_r == 1'(i) && (clear || wrap_s[i]))
          div_r[i] <= pend_div_r;
        else
          div_r[i] <= div_r[i];
      end

      if (pend_r) begin
        if (clear || wrap_s[pend_sel_r]) pend_r <= 1'b0;
        else                             pend_r <= 1'b1;
      end else if (accept_s && !direct_s) begin
        pend_r     <= 1'b1;
        pend_sel_r <= cfg_sel;
        pend_div_r <= cfg_div;
      end else begin
        pend_r <= 1'b0;
      end
    end
  end

  assign tick_cont = tick_r[0];
  assign tick_ru   = tick_r[1];
  assign running   = running_r;
  assign cfg_err   = err_r;
  assign cfg_ready = ~pend_r;

endmodule
